// File: rtl/branch_resolve_unit_if.sv
// branch_resolve_unit_if: prediction/resolution handshake and predictor/redirect outputs
interface branch_resolve_unit_if;
  logic       pred_valid;
  logic [7:0] pred_pc;
  logic       pred_taken;
  logic [7:0] pred_target;
  logic       pred_ready;
  logic       res_valid;
  logic       res_taken;
  logic [7:0] res_target;
  logic       update;
  logic       actual_taken;
  logic [3:0] upd_index;
  logic       flush;
  logic       redirect_valid;
  logic [7:0] redirect_pc;
  logic [7:0] mispredict_cnt;
  logic       err_underflow;
  modport master (
    output pred_valid, pred_pc, pred_taken, pred_target, res_valid, res_taken, res_target,
    input  pred_ready, update, actual_taken, upd_index, flush, redirect_valid, redirect_pc,
           mispredict_cnt, err_underflow
  );
  modport slave (
    input  pred_valid, pred_pc, pred_taken, pred_target, res_valid, res_taken, res_target,
    output pred_ready, update, actual_taken, upd_index, flush, redirect_valid, redirect_pc,
           mispredict_cnt, err_underflow
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: in-order branch resolution, predictor update and mispredict recovery
module branch_resolve_unit #(
  parameter int DEPTH          = 4,
  parameter int RECOVER_CYCLES = 2
) (
  input logic clk,
  input logic reset,
  branch_resolve_unit_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int RW = RECOVER_CYCLES > 1 ? $clog2(RECOVER_CYCLES) : 1;
  typedef enum logic {NORMAL, RECOVER} state_t;
  state_t        state;
  logic [RW-1:0] rcnt;
  logic [7:0]    pc_q [DEPTH];
  logic          tk_q [DEPTH];
  logic [7:0]    tg_q [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   count;
  logic          update, actual_taken, flush, err_underflow;
  logic [3:0]    upd_index;
  logic [7:0]    redirect_pc, mispredict_cnt;
  logic          ready, push, pop, mis;
  always_comb begin
    ready = state == NORMAL && count != (AW+1)'(DEPTH);
    push  = bus.pred_valid && ready;
    pop   = bus.res_valid && state == NORMAL && count != '0;
    mis   = pop && (bus.res_taken != tk_q[rp] || (bus.res_taken && bus.res_target != tg_q[rp]));
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= NORMAL;
      rcnt           <= '0;
      wp             <= '0;
      rp             <= '0;
      count          <= '0;
      update         <= 1'b0;
      actual_taken   <= 1'b0;
      upd_index      <= '0;
      flush          <= 1'b0;
      redirect_pc    <= '0;
      mispredict_cnt <= '0;
      err_underflow  <= 1'b0;
    end else begin
      update <= pop;
      flush  <= mis;
      if (pop) begin
        actual_taken <= bus.res_taken;
        upd_index    <= pc_q[rp][3:0];
      end
      if (bus.res_valid && state == NORMAL && count == '0)
        err_underflow <= 1'b1;
      if (mis) begin
        // a mispredict squashes everything younger, including a same-cycle push
        redirect_pc    <= bus.res_taken ? bus.res_target : pc_q[rp] + 8'd1;
        mispredict_cnt <= mispredict_cnt == 8'hFF ? 8'hFF : mispredict_cnt + 8'd1;
        wp             <= '0;
        rp             <= '0;
        count          <= '0;
        state          <= RECOVER;
        rcnt           <= RW'(RECOVER_CYCLES - 1);
      end else begin
        if (push) begin
          pc_q[wp] <= bus.pred_pc;
          tk_q[wp] <= bus.pred_taken;
          tg_q[wp] <= bus.pred_target;
          wp       <= wp + 1'b1;
        end
        if (pop)
          rp <= rp + 1'b1;
        count <= count + (AW+1)'(push) - (AW+1)'(pop);
        if (state == RECOVER) begin
          state <= rcnt == '0 ? NORMAL : RECOVER;
          rcnt  <= rcnt == '0 ? '0 : rcnt - 1'b1;
        end
      end
    end
  end
  assign bus.pred_ready     = ready;
  assign bus.update         = update;
  assign bus.actual_taken   = actual_taken;
  assign bus.upd_index      = upd_index;
  assign bus.flush          = flush;
  assign bus.redirect_valid = flush;
  assign bus.redirect_pc    = redirect_pc;
  assign bus.mispredict_cnt = mispredict_cnt;
  assign bus.err_underflow  = err_underflow;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: directed and random stimulus against a queue-based reference model
module tb_branch_resolve_unit;
  localparam int DEPTH = 4;
  localparam int RC    = 2;
  typedef struct {logic [7:0] pc; logic tk; logic [7:0] tg;} ent_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int errors = 0;
  ent_t q[$];
  int rec = 0;
  int mc = 0;
  logic er = 1'b0;
  logic e_up = 1'b0, e_fl = 1'b0, e_at = 1'b0;
  logic [3:0] e_ix = '0;
  logic [7:0] e_rpc = '0;
  branch_resolve_unit_if bus ();
  branch_resolve_unit #(.DEPTH(DEPTH), .RECOVER_CYCLES(RC)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step(input bit pv, input logic [7:0] pc, input bit pt, input logic [7:0] ptg,
                      input bit rv, input bit rt, input logic [7:0] rtg, input bit rs = 1'b0);
    bit rdy, mis;
    ent_t h;
    reset = rs;
    bus.pred_valid = pv; bus.pred_pc = pc; bus.pred_taken = pt; bus.pred_target = ptg;
    bus.res_valid = rv; bus.res_taken = rt; bus.res_target = rtg;
    rdy = rec == 0 && q.size() < DEPTH;
    #1;
    if (!rs) chk("pred_ready", 8'(bus.pred_ready), 8'(rdy));
    @(posedge clk);
    if (rs) begin
      q.delete(); rec = 0; mc = 0; er = 1'b0;
      e_up = 1'b0; e_fl = 1'b0; e_at = 1'b0; e_ix = '0; e_rpc = '0;
    end else begin
      e_up = 1'b0; e_fl = 1'b0; mis = 1'b0;
      if (rec > 0) rec--;
      else begin
        if (rv && q.size() == 0) er = 1'b1;
        else if (rv) begin
          h = q.pop_front();
          e_up = 1'b1; e_at = rt; e_ix = h.pc[3:0];
          mis = (rt != h.tk) || (rt && rtg != h.tg);
          if (mis) begin
            e_fl = 1'b1;
            e_rpc = rt ? rtg : h.pc + 8'd1;
            q.delete();
            rec = RC;
            if (mc < 255) mc++;
          end
        end
        if (pv && rdy && !mis) q.push_back('{pc, pt, ptg});
      end
    end
    #1;
    chk("update", 8'(bus.update), 8'(e_up));
    chk("flush", 8'(bus.flush), 8'(e_fl));
    chk("redirect_valid", 8'(bus.redirect_valid), 8'(e_fl));
    chk("mispredict_cnt", bus.mispredict_cnt, 8'(mc));
    chk("err_underflow", 8'(bus.err_underflow), 8'(er));
    if (e_up || rs) begin
      chk("actual_taken", 8'(bus.actual_taken), 8'(e_at));
      chk("upd_index", 8'(bus.upd_index), 8'(e_ix));
    end
    if (e_fl || rs) chk("redirect_pc", bus.redirect_pc, e_rpc);
  endtask
  task automatic idle(input int n = 1);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic push(input logic [7:0] pc, input bit pt, input logic [7:0] ptg);
    step(1, pc, pt, ptg, 0, 0, 0);
  endtask
  task automatic resolve(input bit rt, input logic [7:0] rtg);
    step(0, 0, 0, 0, 1, rt, rtg);
  endtask
  initial begin
    bus.pred_valid = 0; bus.pred_pc = 0; bus.pred_taken = 0; bus.pred_target = 0;
    bus.res_valid = 0; bus.res_taken = 0; bus.res_target = 0;
    step(0, 0, 0, 0, 0, 0, 0, 1'b1);
    idle();
    // correct prediction
    push(8'h13, 1, 8'h40);
    resolve(1, 8'h40);
    chk("correct_upd_index", 8'(bus.upd_index), 8'h03);
    chk("correct_flush", 8'(bus.flush), 8'h00);
    // direction mispredict with younger entries squashed
    push(8'h25, 0, 8'h00);
    push(8'h26, 0, 8'h00);
    push(8'h27, 0, 8'h00);
    resolve(1, 8'h60);
    chk("dir_redirect_pc", bus.redirect_pc, 8'h60);
    chk("dir_upd_index", 8'(bus.upd_index), 8'h05);
    push(8'h30, 0, 8'h00);
    push(8'h31, 0, 8'h00);
    chk("dir_ready_after_recover", 8'(bus.pred_ready), 8'h01);
    resolve(0, 8'h00);
    chk("dir_queue_emptied_underflow", 8'(bus.err_underflow), 8'h01);
    step(0, 0, 0, 0, 0, 0, 0, 1'b1);
    // not-taken redirect wraps pc
    push(8'hFF, 1, 8'h10);
    resolve(0, 8'h00);
    chk("wrap_redirect_pc", bus.redirect_pc, 8'h00);
    chk("wrap_actual_taken", 8'(bus.actual_taken), 8'h00);
    idle(RC);
    // full queue, pop-only with blocked push, then push+pop
    for (int i = 0; i < 4; i++) push(8'h50 + 8'(i), 0, 8'h00);
    push(8'h5F, 0, 8'h00);
    step(1, 8'h60, 0, 0, 1, 0, 0);
    step(1, 8'h61, 0, 0, 1, 0, 0);
    push(8'h62, 0, 8'h00);
    push(8'h63, 0, 8'h00);
    for (int i = 0; i < 4; i++) resolve(0, 0);
    // underflow then saturation
    resolve(0, 0);
    chk("underflow_update", 8'(bus.update), 8'h00);
    for (int i = 0; i < 256; i++) begin
      push(8'(i), 0, 8'h00);
      resolve(1, 8'(i));
      idle(RC);
    end
    chk("saturated_cnt", bus.mispredict_cnt, 8'hFF);
    // reset one cycle after flush
    push(8'h44, 1, 8'h80);
    resolve(1, 8'h81);
    step(0, 0, 0, 0, 0, 0, 0, 1'b1);
    chk("rst_cnt", bus.mispredict_cnt, 8'h00);
    idle();
    chk("rst_ready", 8'(bus.pred_ready), 8'h01);
    // random traffic
    for (int i = 0; i < 1500; i++) begin
      bit pv, pt, rv, rt, rs;
      logic [7:0] pc, ptg, rtg;
      pv = 1'($urandom_range(0, 1)); pc = 8'($urandom); pt = 1'($urandom_range(0, 1));
      ptg = 8'($urandom_range(0, 3)); rv = 1'($urandom_range(0, 1));
      rt = 1'($urandom_range(0, 1)); rtg = 8'($urandom_range(0, 3));
      rs = $urandom_range(0, 63) == 0;
      if (q.size() > 0 && $urandom_range(0, 3) != 0) begin
        rt = q[0].tk; rtg = q[0].tg;
      end
      if (rv && q.size() == 0) pv = 1'b0;
      step(pv, pc, pt, ptg, rv, rt, rtg, rs);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/branch_resolve_unit.md
BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 SHALL have parameters:
- DEPTH, 4: in-flight prediction queue entries (power of 2).
- RECOVER_CYCLES, 2: RECOVER state length after a mispredict (>=1).

REQ-002 SHALL have ports:
- clk, input, 1: single clock; all state updates on posedge.
- reset, input, 1: synchronous, active-high.
- pred_valid, input, 1: fetch issues a predicted branch this cycle.
- pred_pc, input, 8: PC of the issued branch.
- pred_taken, input, 1: predictor's taken/not-taken decision.
- pred_target, input, 8: target fetch used if predicted taken.
- pred_ready, output, 1: queue can accept an entry.
- res_valid, input, 1: execute resolves the oldest in-flight branch.
- res_taken, input, 1: actual branch direction.
- res_target, input, 8: actual branch target.
- update, output, 1: one-cycle pulse; predictor table write enable.
- actual_taken, output, 1: resolved direction to predictor, valid with update.
- upd_index, output, 4: predictor index = resolved pc[3:0], valid with update.
- flush, output, 1: one-cycle pulse; squash younger pipeline work.
- redirect_valid, output, 1: one-cycle pulse, coincident with flush.
- redirect_pc, output, 8: correct fetch PC, valid with redirect_valid.
- mispredict_cnt, output, 8: saturating mispredict count.
- err_underflow, output, 1: sticky; set by res_valid while queue empty.

Function
REQ-003 SHALL keep a FIFO of DEPTH entries {pc, taken, target}, with wrapping read/write pointers and a count of width log2(DEPTH)+1.
REQ-004 pred_ready SHALL be 1 iff state==NORMAL and count<DEPTH; it is combinational from registered state.
REQ-005 A push SHALL occur on pred_valid && pred_ready; pred_valid while pred_ready==0 SHALL be ignored, with no state change.
REQ-006 res_valid with count>0 in NORMAL SHALL pop the head entry; resolution SHALL be strictly in order.
REQ-007 Push and non-mispredict pop in the same cycle SHALL both take effect; count is unchanged; at count==DEPTH the push is blocked by REQ-004.
REQ-008 The popped entry SHALL be mispredicted iff res_taken!=head.taken, or res_taken && head.taken && res_target!=head.target.
REQ-009 Every pop SHALL produce, registered, in the next cycle:
- update=1;
- actual_taken=res_taken;
- upd_index=head.pc[3:0].
Fixed latency is 1 cycle.
REQ-010 On a mispredicted pop, the next cycle SHALL also assert flush=1 and redirect_valid=1.
- redirect_pc = res_target if res_taken, else head.pc+1 (mod 256, 8'hFF -> 8'h00).
REQ-011 On a mispredicted pop, the queue SHALL be emptied (pointers and count to 0), and any same-cycle push SHALL be discarded.
REQ-012 State machine:
- NORMAL -> RECOVER on a mispredicted pop.
- RECOVER holds RECOVER_CYCLES cycles via a down-counter, then -> NORMAL.
- No other transitions.
REQ-013 In RECOVER: pred_valid and res_valid SHALL be ignored; update, flush and redirect_valid stay 0 after the REQ-010 pulse.
REQ-014 mispredict_cnt SHALL increment by 1 per mispredict and saturate at 8'hFF.
REQ-015 res_valid with count==0 in NORMAL SHALL set err_underflow, with no pop, no update and no other state change.
REQ-016 update, flush and redirect_valid SHALL be 0 in every cycle not defined above.

Reset
REQ-017 reset SHALL take priority over all inputs and, at the next posedge, set:
- count=0, pointers=0, state=NORMAL;
- update=0, actual_taken=0, upd_index=0, flush=0, redirect_valid=0, redirect_pc=0;
- mispredict_cnt=0, err_underflow=0.
REQ-018 reset mid-RECOVER or with a non-empty queue SHALL discard all entries; pred_ready=1 the cycle after reset deasserts.

Verification
REQ-019 Bench SHALL cover:
- Correct predict: push {pc=8'h13, taken=1, target=8'h40}; then res_valid, res_taken=1, res_target=8'h40 -> next cycle update=1, actual_taken=1, upd_index=4'h3, flush=0; mispredict_cnt=0.
- Direction mispredict: push {8'h25, 0, 8'h00}, 8'h26, 8'h27; resolve res_taken=1, target=8'h60 -> next cycle flush=1, redirect_pc=8'h60, upd_index=4'h5; count=0; pred_ready=0 for 2 cycles, then 1.
- Not-taken redirect at wrap: push {8'hFF, 1, 8'h10}; resolve res_taken=0 -> redirect_pc=8'h00, actual_taken=0, flush=1.
- Full/simultaneous: fill 4 entries -> pred_ready=0; then res_valid (correct) with pred_valid -> pop only, count 3; next push+pop same cycle -> count stays 3.
- Underflow and saturation: res_valid on empty -> err_underflow=1, update=0; 256 mispredicts -> mispredict_cnt=8'hFF.
- Reset mid-RECOVER: reset one cycle after flush -> all outputs 0, count=0, pred_ready=1 the following cycle.
